// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry registered output buffer over a shared 64-bit 4:1 select path.
// The select datapath is split into lane slices so the mux stays a flat, narrow structure.

module mux4_rr_lane #(
  parameter int VEC_W = 16
) (
  input  logic [1:0]            sel,
  input  logic [3:0][VEC_W-1:0] din,
  output logic [VEC_W-1:0]      dout
);
  always_comb dout = din[sel];
endmodule

module mux4_rr_arbiter #(
  parameter logic [1:0] RESET_PTR = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] data_1,
  input  logic [63:0] data_2,
  input  logic [63:0] data_3,
  input  logic [63:0] data_4,
  output logic [3:0]  gnt,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic [1:0]  out_src,
  input  logic        out_ready
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 64 / NUM_LANES;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  src;
  } resp_t;

  logic [0:0] state;
  logic [1:0] ptr;
  resp_t      out_q;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       load;

  logic [3:0][63:0]                       src_data;
  logic [NUM_LANES-1:0][3:0][VEC_W-1:0]   lane_in;
  logic [NUM_LANES-1:0][VEC_W-1:0]        lane_out;

  assign src_data = {data_4, data_3, data_2, data_1};

  // Reset gates load so gnt stays quiet while reset is asserted.
  assign load = (|req) & ((state == IDLE) | out_ready) & reset;

  // Search starts at ptr and wraps; the first requester found wins.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign gnt = load ? (4'b0001 << winner) : 4'b0000;

  genvar l, s;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      for (s = 0; s < 4; s++) begin : g_src
        assign lane_in[l][s] = src_data[s][l*VEC_W +: VEC_W];
      end
      mux4_rr_lane #(.VEC_W(VEC_W)) u_lane (
        .sel  (winner),
        .din  (lane_in[l]),
        .dout (lane_out[l])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      out_q <= '0;
      ptr   <= RESET_PTR;
    end else if (load) begin
      state      <= FULL;
      out_q.data <= lane_out;
      out_q.src  <= winner;
      ptr        <= winner + 2'd1;
    end else if ((state == FULL) && out_ready) begin
      // Drained with nothing to refill; payload is kept for visibility.
      state <= IDLE;
    end
  end

  assign out_valid = (state == FULL);
  assign out_data  = out_q.data;
  assign out_src   = out_q.src;
endmodule
